// File: rtl/float_pkg.sv
// Shared floating-point helpers: exponent mask, quiet-NaN pattern and the
// classification flag struct used by the multiplier, adder and this stage.
package float_pkg;

    localparam int MAX_FLOAT_WIDTH = 64;

    typedef struct packed {
        logic is_infinite;
        logic is_zero;
        logic is_signaling_nan;
        logic is_quiet_nan;
        logic is_subnormal;
    } float_class_t;

    // Low exp_width bits set; callers slice the width they need.
    function automatic logic [MAX_FLOAT_WIDTH-1:0] exp_ones_mask(input int exp_width);
        logic [MAX_FLOAT_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_FLOAT_WIDTH; i++) begin
            if (i < exp_width) mask[i] = 1'b1;
        end
        return mask;
    endfunction

    // Canonical positive quiet NaN: exponent all-ones, fraction MSB set.
    function automatic logic [MAX_FLOAT_WIDTH-1:0] quiet_nan(input int exp_width,
                                                             input int mant_width);
        logic [MAX_FLOAT_WIDTH-1:0] one;
        one = 1;
        return (exp_ones_mask(exp_width) << mant_width) | (one << (mant_width - 1));
    endfunction

endpackage

// File: rtl/float_rne_rounder.sv
// Combinational mantissa/exponent rounder: guard/sticky decode, increment,
// carry into the exponent and overflow (infinity or E4M3 saturation).
module float_rne_rounder
    import float_pkg::*;
#(
    parameter int EXPONENT_WIDTH   = 8,
    parameter int MANTISSA_WIDTH   = 23,
    parameter int ROUND_TO_NEAREST = 1,
    parameter int ROUNDING_BITS    = MANTISSA_WIDTH + 1,
    parameter bit E4M3_MODE        = 1'b0
) (
    input  logic [EXPONENT_WIDTH-1:0] exponent,
    input  logic [MANTISSA_WIDTH-1:0] mantissa,
    input  logic [ROUNDING_BITS-1:0]  rounding_bits,
    output logic [EXPONENT_WIDTH-1:0] rounded_exponent,
    output logic [MANTISSA_WIDTH-1:0] rounded_mantissa,
    output logic                      overflow_flag
);

    localparam int EW = EXPONENT_WIDTH;
    localparam int MW = MANTISSA_WIDTH;
    localparam logic [MAX_FLOAT_WIDTH-1:0] EXP_MASK_WIDE = exp_ones_mask(EW);
    localparam logic [EW-1:0] EXP_ONES  = EXP_MASK_WIDE[EW-1:0];
    localparam logic [MW-1:0] MANT_ONES = '1;
    localparam logic [MW-1:0] MANT_LSB  = MW'(1);
    localparam logic [MW-1:0] MANT_SAT  = MANT_ONES & ~MANT_LSB;

    logic          guard;
    logic          sticky;
    logic          increment;
    logic          carry;
    logic          pass_through;
    logic [MW-1:0] mant_inc;
    logic [EW-1:0] exp_inc;

    always_comb begin
        guard        = rounding_bits[ROUNDING_BITS-1];
        sticky       = |rounding_bits[ROUNDING_BITS-2:0];
        increment    = (ROUND_TO_NEAREST != 0) && guard && (sticky || mantissa[0]);
        {carry, mant_inc} = {1'b0, mantissa} + (MW+1)'(increment);
        exp_inc      = exponent + EW'(carry);
        pass_through = 1'b0;

        rounded_exponent = exponent;
        rounded_mantissa = mantissa;
        overflow_flag    = 1'b0;

        if (E4M3_MODE) begin
            // Only 1111/111 is special (NaN); every other 1111 code is a normal number.
            pass_through = (exponent == EXP_ONES) && (mantissa == MANT_ONES);
            if (!pass_through) begin
                if ((exp_inc == EXP_ONES) && (mant_inc == MANT_ONES)) begin
                    rounded_exponent = EXP_ONES;
                    rounded_mantissa = MANT_SAT;
                    overflow_flag    = 1'b1;
                end else begin
                    rounded_exponent = exp_inc;
                    rounded_mantissa = mant_inc;
                end
            end
        end else begin
            pass_through = (exponent == EXP_ONES);
            if (!pass_through) begin
                if (exp_inc == EXP_ONES) begin
                    rounded_exponent = EXP_ONES;
                    rounded_mantissa = '0;
                    overflow_flag    = 1'b1;
                end else begin
                    rounded_exponent = exp_inc;
                    rounded_mantissa = mant_inc;
                end
            end
        end
    end

endmodule

// File: rtl/float_classify_round.sv
// Registered classify + round stage. Define FLOAT_CLASSIFY_ROUND_E4M3_EN (with
// 4/3 widths) for OCP FP8 E4M3 semantics; otherwise IEEE layout rules apply.
module float_classify_round
    import float_pkg::*;
#(
    parameter int EXPONENT_WIDTH   = 8,
    parameter int MANTISSA_WIDTH   = 23,
    parameter int ROUND_TO_NEAREST = 1,
    parameter int ROUNDING_BITS    = MANTISSA_WIDTH + 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]   a,
    input  logic [EXPONENT_WIDTH-1:0]                non_rounded_exponent,
    input  logic [MANTISSA_WIDTH-1:0]                non_rounded_mantissa,
    input  logic [ROUNDING_BITS-1:0]                 rounding_bits,
    output logic                                     out_valid,
    output logic                                     is_infinite,
    output logic                                     is_zero,
    output logic                                     is_signaling_nan,
    output logic                                     is_quiet_nan,
    output logic                                     is_subnormal,
    output logic [EXPONENT_WIDTH-1:0]                rounded_exponent,
    output logic [MANTISSA_WIDTH-1:0]                rounded_mantissa,
    output logic                                     overflow_flag
);

    localparam int EW = EXPONENT_WIDTH;
    localparam int MW = MANTISSA_WIDTH;
`ifdef FLOAT_CLASSIFY_ROUND_E4M3_EN
    localparam bit E4M3_MODE = (EW == 4) && (MW == 3);
`else
    localparam bit E4M3_MODE = 1'b0;
`endif
    localparam logic [MAX_FLOAT_WIDTH-1:0] EXP_MASK_WIDE = exp_ones_mask(EW);
    localparam logic [EW-1:0] EXP_ONES  = EXP_MASK_WIDE[EW-1:0];
    localparam logic [MW-1:0] MANT_ONES = '1;

    logic          unused_sign;
    logic [EW-1:0] a_exp;
    logic [MW-1:0] a_mant;
    float_class_t  class_d;
    float_class_t  class_q;
    logic [EW-1:0] round_exp_d;
    logic [MW-1:0] round_mant_d;
    logic          round_ovf_d;

    assign unused_sign = a[EW+MW];
    assign a_exp       = a[EW+MW-1:MW];
    assign a_mant      = a[MW-1:0];

    always_comb begin
        class_d = '0;
        class_d.is_zero      = (a_exp == '0) && (a_mant == '0);
        class_d.is_subnormal = (a_exp == '0) && (a_mant != '0);
        if (E4M3_MODE) begin
            class_d.is_quiet_nan = (a_exp == EXP_ONES) && (a_mant == MANT_ONES);
        end else begin
            class_d.is_infinite      = (a_exp == EXP_ONES) && (a_mant == '0);
            class_d.is_quiet_nan     = (a_exp == EXP_ONES) && a_mant[MW-1];
            class_d.is_signaling_nan = (a_exp == EXP_ONES) && !a_mant[MW-1] && (a_mant != '0);
        end
    end

    float_rne_rounder #(
        .EXPONENT_WIDTH  (EW),
        .MANTISSA_WIDTH  (MW),
        .ROUND_TO_NEAREST(ROUND_TO_NEAREST),
        .ROUNDING_BITS   (ROUNDING_BITS),
        .E4M3_MODE       (E4M3_MODE)
    ) u_rounder (
        .exponent        (non_rounded_exponent),
        .mantissa        (non_rounded_mantissa),
        .rounding_bits   (rounding_bits),
        .rounded_exponent(round_exp_d),
        .rounded_mantissa(round_mant_d),
        .overflow_flag   (round_ovf_d)
    );

    // Valid protocol: in_valid qualifies every data input in its cycle; there is
    // no ready, so a beat is taken every cycle and out_valid is in_valid one edge
    // later. Idle cycles leave the data registers holding the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid        <= 1'b0;
            class_q          <= '0;
            rounded_exponent <= '0;
            rounded_mantissa <= '0;
            overflow_flag    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                class_q          <= class_d;
                rounded_exponent <= round_exp_d;
                rounded_mantissa <= round_mant_d;
                overflow_flag    <= round_ovf_d;
            end
        end
    end

    assign is_infinite      = class_q.is_infinite;
    assign is_zero          = class_q.is_zero;
    assign is_signaling_nan = class_q.is_signaling_nan;
    assign is_quiet_nan     = class_q.is_quiet_nan;
    assign is_subnormal     = class_q.is_subnormal;

endmodule

// File: tb/tb_float_classify_round.sv
// Self-checking bench for float_classify_round (FP32 defaults, RNE and RTZ
// instances) against an arithmetic reference model.
module tb_float_classify_round;

    localparam int W = 38;  // {valid, inf, zero, snan, qnan, sub, ovf, exp[7:0], mant[22:0]}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [7:0]  nre = '0;
    logic [22:0] nrm = '0;
    logic [23:0] rbits = '0;

    logic        n_valid, n_inf, n_zero, n_snan, n_qnan, n_sub, n_ovf;
    logic [7:0]  n_exp;
    logic [22:0] n_mant;
    logic        z_valid, z_inf, z_zero, z_snan, z_qnan, z_sub, z_ovf;
    logic [7:0]  z_exp;
    logic [22:0] z_mant;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_rtz_q[$];
    logic [W-1:0] last_n = '0;
    logic [W-1:0] last_z = '0;
    logic [W-1:0] e_n, e_z;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    float_classify_round dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a),
        .non_rounded_exponent(nre), .non_rounded_mantissa(nrm), .rounding_bits(rbits),
        .out_valid(n_valid), .is_infinite(n_inf), .is_zero(n_zero),
        .is_signaling_nan(n_snan), .is_quiet_nan(n_qnan), .is_subnormal(n_sub),
        .rounded_exponent(n_exp), .rounded_mantissa(n_mant), .overflow_flag(n_ovf)
    );

    float_classify_round #(.ROUND_TO_NEAREST(0)) dut_rtz (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a),
        .non_rounded_exponent(nre), .non_rounded_mantissa(nrm), .rounding_bits(rbits),
        .out_valid(z_valid), .is_infinite(z_inf), .is_zero(z_zero),
        .is_signaling_nan(z_snan), .is_quiet_nan(z_qnan), .is_subnormal(z_sub),
        .rounded_exponent(z_exp), .rounded_mantissa(z_mant), .overflow_flag(z_ovf)
    );

    wire [W-1:0] obs_n = {n_valid, n_inf, n_zero, n_snan, n_qnan, n_sub, n_ovf, n_exp, n_mant};
    wire [W-1:0] obs_z = {z_valid, z_inf, z_zero, z_snan, z_qnan, z_sub, z_ovf, z_exp, z_mant};

    // Classification by magnitude ranges: returns {inf, zero, snan, qnan, sub}.
    function automatic logic [4:0] model_class(input logic [31:0] x);
        logic [30:0] mag;
        logic [4:0]  r;
        mag = x[30:0];
        r = '0;
        if (mag == 31'd0)                 r[3] = 1'b1;
        else if (mag < 31'h00800000)      r[0] = 1'b1;
        else if (mag == 31'h7F800000)     r[4] = 1'b1;
        else if (mag >= 31'h7FC00000)     r[1] = 1'b1;
        else if (mag > 31'h7F800000)      r[2] = 1'b1;
        return r;
    endfunction

    // Rounding on the combined exponent:mantissa integer; returns {ovf, exp, mant}.
    function automatic logic [31:0] model_round(input logic [7:0] e, input logic [22:0] m,
                                                input logic [23:0] b, input logic rtn);
        longint v;
        longint inc;
        if (e == 8'hFF) return {1'b0, e, m};
        inc = 0;
        if (rtn) begin
            if (b > 24'h800000) inc = 1;
            else if (b == 24'h800000 && (m % 2 == 1)) inc = 1;
        end
        v = (longint'(e) << 23) + longint'(m) + inc;
        if (v >= (longint'(255) << 23)) return {1'b1, 8'hFF, 23'd0};
        return {1'b0, v[30:0]};
    endfunction

    task automatic apply(input logic v, input logic [31:0] aa, input logic [7:0] e,
                         input logic [22:0] m, input logic [23:0] b);
        @(negedge clk);
        in_valid = v;
        a = aa;
        nre = e;
        nrm = m;
        rbits = b;
        if (v) begin
            last_n = {1'b1, model_class(aa), model_round(e, m, b, 1'b1)};
            last_z = {1'b1, model_class(aa), model_round(e, m, b, 1'b0)};
        end else begin
            last_n[W-1] = 1'b0;
            last_z[W-1] = 1'b0;
        end
        exp_q.push_back(last_n);
        exp_rtz_q.push_back(last_z);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (obs_n !== '0) begin
            errors++;
            $display("FAIL reset_rne got=%h exp=0", obs_n);
        end
        checks++;
        if (obs_z !== '0) begin
            errors++;
            $display("FAIL reset_rtz got=%h exp=0", obs_z);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_classify();
        logic [31:0] vals[5];
        logic [4:0]  flags[5];
        vals  = '{32'h7F800000, 32'h7FC00000, 32'h7F800001, 32'h80000000, 32'h00000001};
        flags = '{5'b10000, 5'b00010, 5'b00100, 5'b01000, 5'b00001};
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, vals[i], 8'h7F, 23'd0, 24'd0);
            @(posedge clk);
            #1;
            e_n = exp_q.pop_front();
            e_z = exp_rtz_q.pop_front();
            checks++;
            if (obs_n !== e_n) begin
                errors++;
                $display("FAIL classify_model a=%h got=%h exp=%h", vals[i], obs_n, e_n);
            end
            checks++;
            if ({obs_n[37], obs_n[36:32]} !== {1'b1, flags[i]}) begin
                errors++;
                $display("FAIL classify_flags a=%h got=%b exp=1_%b", vals[i],
                         obs_n[37:32], flags[i]);
            end
        end
    endtask

    task automatic test_round_directed();
        logic [7:0]  es[5];
        logic [22:0] ms[5];
        logic [23:0] bs[5];
        logic [31:0] rs[5];
        es = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'hFE};
        ms = '{23'h000000, 23'h000001, 23'h000000, 23'h7FFFFF, 23'h7FFFFF};
        bs = '{24'h800000, 24'h800000, 24'h800001, 24'hC00000, 24'h800000};
        rs = '{{1'b0, 8'h7F, 23'h0}, {1'b0, 8'h7F, 23'h2}, {1'b0, 8'h7F, 23'h1},
               {1'b0, 8'h80, 23'h0}, {1'b1, 8'hFF, 23'h0}};
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 32'h3F800000, es[i], ms[i], bs[i]);
            @(posedge clk);
            #1;
            e_n = exp_q.pop_front();
            e_z = exp_rtz_q.pop_front();
            checks++;
            if (obs_n[31:0] !== rs[i]) begin
                errors++;
                $display("FAIL round_case%0d got=%h exp=%h", i, obs_n[31:0], rs[i]);
            end
            checks++;
            if (obs_n !== e_n) begin
                errors++;
                $display("FAIL round_model%0d got=%h exp=%h", i, obs_n, e_n);
            end
        end
        apply(1'b1, 32'h3F800000, 8'h10, 23'h123456, 24'hFFFFFF);
        @(posedge clk);
        #1;
        e_n = exp_q.pop_front();
        e_z = exp_rtz_q.pop_front();
        checks++;
        if (obs_z[31:0] !== {1'b0, 8'h10, 23'h123456}) begin
            errors++;
            $display("FAIL rtz_passthru got=%h exp=%h", obs_z[31:0], {1'b0, 8'h10, 23'h123456});
        end
        checks++;
        if (obs_z !== e_z) begin
            errors++;
            $display("FAIL rtz_model got=%h exp=%h", obs_z, e_z);
        end
    endtask

    task automatic test_hold();
        apply(1'b1, 32'h00400000, 8'h55, 23'h2AAAAA, 24'hA00000);
        @(posedge clk);
        #1;
        e_n = exp_q.pop_front();
        e_z = exp_rtz_q.pop_front();
        checks++;
        if (obs_n !== e_n) begin
            errors++;
            $display("FAIL hold_load got=%h exp=%h", obs_n, e_n);
        end
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 32'h7F800000, 8'hFE, 23'h7FFFFF, 24'hFFFFFF);
            @(posedge clk);
            #1;
            e_n = exp_q.pop_front();
            e_z = exp_rtz_q.pop_front();
            checks++;
            if (obs_n !== e_n || obs_z !== e_z) begin
                errors++;
                $display("FAIL hold_idle%0d got=%h/%h exp=%h/%h", i, obs_n, obs_z, e_n, e_z);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ra;
        logic [7:0]  re;
        logic [22:0] rm;
        logic [23:0] rb;
        logic        rv;
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 3))
                0: ra[30:23] = 8'h00;
                1: ra[30:23] = 8'hFF;
                default: ra[30:23] = 8'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: ra[22:0] = 23'd0;
                1: ra[22:0] = 23'($urandom_range(0, 3));
                default: ra[22:0] = 23'($urandom);
            endcase
            ra[31] = 1'($urandom);
            case ($urandom_range(0, 3))
                0: re = 8'hFE;
                1: re = 8'hFF;
                default: re = 8'($urandom);
            endcase
            rm = ($urandom_range(0, 2) == 0) ? 23'h7FFFFF : 23'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 24'h800000;
                1: rb = 24'h000000;
                2: rb = 24'h800000 | 24'($urandom_range(0, 1));
                default: rb = 24'($urandom);
            endcase
            apply(rv, ra, re, rm, rb);
            @(posedge clk);
            #1;
            e_n = exp_q.pop_front();
            e_z = exp_rtz_q.pop_front();
            checks++;
            if (obs_n !== e_n) begin
                errors++;
                $display("FAIL rand_rne%0d got=%h exp=%h", i, obs_n, e_n);
            end
            checks++;
            if (obs_z !== e_z) begin
                errors++;
                $display("FAIL rand_rtz%0d got=%h exp=%h", i, obs_z, e_z);
            end
        end
    endtask

    task automatic test_reset_midstream();
        apply(1'b1, 32'h7FC00000, 8'h20, 23'h000003, 24'hC00000);
        @(posedge clk);
        #1;
        e_n = exp_q.pop_front();
        e_z = exp_rtz_q.pop_front();
        checks++;
        if (obs_n !== e_n) begin
            errors++;
            $display("FAIL pre_reset got=%h exp=%h", obs_n, e_n);
        end
        apply(1'b1, 32'h7F800000, 8'h21, 23'h000005, 24'h800000);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_n !== '0 || obs_z !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h/%h exp=0", obs_n, obs_z);
        end
        exp_q.delete();
        exp_rtz_q.delete();
        last_n = '0;
        last_z = '0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, 32'h0, 8'h0, 23'h0, 24'h0);
        @(posedge clk);
        #1;
        e_n = exp_q.pop_front();
        e_z = exp_rtz_q.pop_front();
        checks++;
        if (obs_n !== e_n) begin
            errors++;
            $display("FAIL post_reset_idle got=%h exp=%h", obs_n, e_n);
        end
        apply(1'b1, 32'h80000001, 8'h7E, 23'h000001, 24'h800000);
        @(posedge clk);
        #1;
        e_n = exp_q.pop_front();
        e_z = exp_rtz_q.pop_front();
        checks++;
        if (obs_n !== e_n || obs_z !== e_z) begin
            errors++;
            $display("FAIL post_reset_first got=%h/%h exp=%h/%h", obs_n, obs_z, e_n, e_z);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_classify();
        test_round_directed();
        test_hold();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
